rotor_stepping_unit: RTL
========================

Name: rotor_stepping_unit

Overview:
- Three-rotor stepping controller for the Enigma datapath; sits directly upstream of the per-rotor 0–25 position registers and display logic.
- Converts a raw keypress level into exactly one stepping event per press.
- Applies Enigma odometer and double-stepping rules across right, middle and left rotors, holding all three positions internally.
- Exposes positions as 8-bit non-negative values, so they can drive LEDG or downstream substitution logic directly.

Parameters:
- NOTCH_R, 16, right-rotor turnover position (Q); middle rotor steps when right rotor is at this value.
- NOTCH_M, 4, middle-rotor turnover position (E); left rotor steps, and middle double-steps, when middle rotor is at this value.
- NOTCH_L, 21, left-rotor notch (V); reported on at_notch only, no rotor beyond left.

Ports:
- clk  input  1  system clock (CLOCK_50 domain, or rate-divided clk); all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- key_press  input  1  raw keypress level; sampled every clk.
- load  input  1  synchronous load of init positions.
- init_r  input  5  right rotor initial position.
- init_m  input  5  middle rotor initial position.
- init_l  input  5  left rotor initial position.
- pos_r  output  8  right rotor position, 0–25, bits [7:5] always 0.
- pos_m  output  8  middle rotor position, 0–25.
- pos_l  output  8  left rotor position, 0–25.
- step_done  output  1  one-cycle pulse, coincident with updated positions after a step.
- at_notch  output  3  {left,mid,right} position equals that rotor's notch; combinational from registers.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: pos_r = pos_m = pos_l = 0, step_done = 0, key_q = 0.
- Edge detect:
  - key_q <= key_press every cycle.
  - step_evt = key_press & ~key_q.
  - A held key produces exactly one step; the next step needs key_press low for ≥1 cycle.
- Priority per cycle: reset > load > step_evt.
  - On load, step_evt is discarded.
  - key_q still updates during load.
- Load normalisation: init value v in 26–31 loads as v−26; v in 0–25 loads unchanged. Each rotor is normalised independently.
- Step rules, evaluated on pre-step values in the same edge:
  - Right rotor always advances.
  - Middle advances if pos_r==NOTCH_R or pos_m==NOTCH_M (double step).
  - Left advances if pos_m==NOTCH_M.
- Advance arithmetic: 25 → 0 wrap; otherwise +1. Positions never leave 0–25.
- Latency: step_evt sampled at edge N; new positions and step_done=1 visible after edge N. step_done returns to 0 after edge N+1 unless a new step_evt occurs.
- step_done stays 0 on load and reset.
- Reset mid-press: key_q clears. If key_press is still high in the first post-reset cycle, that counts as a new edge and steps once. This is intentional and must be verified.

Test Plan:
- Assert reset 2 cycles -> pos_r/m/l = 0/0/0, step_done = 0, at_notch = 3'b000.
- Load init = (l,m,r)=(0,3,15) (ADP); press 3 separate times -> ADQ (0,3,16); then AER (0,4,17); then BFS (1,5,18); step_done pulses once per press.
- Load (0,0,25); one press -> (0,0,0), no middle/left step. Load (25,25,25) with NOTCH defaults; press -> (25,25,0).
- Hold key_press high 100 cycles after load (0,0,0) -> exactly one step to (0,0,1), exactly one step_done pulse.
- Load init_r=30, init_m=26, init_l=31 -> positions (5,0,4). Load and rising key_press in same cycle -> loaded values, no step, step_done = 0.
- Reset asserted for 1 cycle while key_press held high -> zeros, then one step to (0,0,1) on the following cycle.

Source files
------------

// File: rtl/rotor_stepping_unit.sv
// -----------------------------------------------------------------------------
// rotor_stepping_unit
//
// Three-rotor stepping controller for the Enigma datapath. It turns a raw
// keypress level into one stepping event per press. It applies the odometer
// rule and the double-stepping rule to the right, middle and left rotors, and
// it holds all three rotor positions (0..25) internally.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   key_press  raw keypress level, sampled every cycle
//   load       synchronous load of init_r/init_m/init_l
//   init_r     right rotor initial position (26..31 wraps to 0..5)
//   init_m     middle rotor initial position (26..31 wraps to 0..5)
//   init_l     left rotor initial position (26..31 wraps to 0..5)
//   pos_r      right rotor position, 0..25, zero-extended to 8 bits
//   pos_m      middle rotor position, 0..25, zero-extended to 8 bits
//   pos_l      left rotor position, 0..25, zero-extended to 8 bits
//   step_done  one-cycle pulse that appears together with the stepped positions
//   at_notch   {left, mid, right}: the rotor sits on its notch (from registers)
// -----------------------------------------------------------------------------
module rotor_stepping_unit #(
  parameter int NOTCH_R = 16,
  parameter int NOTCH_M = 4,
  parameter int NOTCH_L = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_press,
  input  logic       load,
  input  logic [4:0] init_r,
  input  logic [4:0] init_m,
  input  logic [4:0] init_l,
  output logic [7:0] pos_r,
  output logic [7:0] pos_m,
  output logic [7:0] pos_l,
  output logic       step_done,
  output logic [2:0] at_notch
);

  // Rotor index 0 = right, 1 = middle, 2 = left throughout.
  localparam logic [14:0] NOTCHES = {NOTCH_L[4:0], NOTCH_M[4:0], NOTCH_R[4:0]};
  localparam logic [4:0]  POS_MAX = 5'd25;

  logic       key_q_reg;
  logic       step_done_reg;
  logic       step_evt;

  logic [4:0] pos_reg   [3];
  logic [4:0] pos_next  [3];
  logic [4:0] init_raw  [3];
  logic [4:0] init_norm [3];
  logic [4:0] adv_pos   [3];
  logic [2:0] notch_hit;
  logic [2:0] advance;

  // Rising-edge detect: a held key yields a single event.
  assign step_evt = key_press & ~key_q_reg;

  assign init_raw[0] = init_r;
  assign init_raw[1] = init_m;
  assign init_raw[2] = init_l;

  // The stepping decision uses only the pre-step positions. The middle rotor
  // moves when the right rotor is on its notch, and it also moves when it is
  // on its own notch (the double step). Only the middle notch drives the left
  // rotor. The left notch is only reported on at_notch.
  assign advance = {notch_hit[1], notch_hit[1] | notch_hit[0], 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rotor
      assign notch_hit[gi] = (pos_reg[gi] == NOTCHES[gi*5 +: 5]);

      // The inputs are 5 bits wide, so 26..31 needs only one subtraction to
      // reach the legal range.
      assign init_norm[gi] = (init_raw[gi] > POS_MAX) ? (init_raw[gi] - 5'd26)
                                                      : init_raw[gi];

      assign adv_pos[gi] = (pos_reg[gi] == POS_MAX) ? 5'd0 : (pos_reg[gi] + 5'd1);

      // A load takes priority over a step event in the same cycle.
      assign pos_next[gi] = load                      ? init_norm[gi] :
                            (step_evt && advance[gi]) ? adv_pos[gi]   :
                                                        pos_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q_reg     <= 1'b0;
      step_done_reg <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        pos_reg[i] <= 5'd0;
      end
    end else begin
      // The key history still follows the key during a load. A press that
      // arrives with a load is used up by the load and does not step later.
      key_q_reg     <= key_press;
      step_done_reg <= step_evt & ~load;
      for (int i = 0; i < 3; i++) begin
        pos_reg[i] <= pos_next[i];
      end
    end
  end

  assign pos_r     = {3'b000, pos_reg[0]};
  assign pos_m     = {3'b000, pos_reg[1]};
  assign pos_l     = {3'b000, pos_reg[2]};
  assign step_done = step_done_reg;
  assign at_notch  = notch_hit;

endmodule
